lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller between the EXU and the data-memory bus. It accepts one memory instruction at a time and checks alignment and funct3. Store lanes are formatted through the existing `STORE_Decoder`, and the controller sequences a valid/ready request and response transaction. Load data is aligned and sign- or zero-extended before a single result is handed back to the WBU.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in WAIT before an error is forced. Legal range is 1..255.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  EXU request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_is_store`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  RV32I load/store funct3.
- `in_addr`  in  32  byte address.
- `in_wdata`  in  32  store source register value.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wen`  out  1  write request.
- `mem_wmask`  out  8  byte write mask.
- `mem_wdata`  out  32  lane-shifted write data.
- `mem_resp_valid`  in  1  bus response valid.
- `mem_rdata`  in  32  read word.
- `mem_resp_err`  in  1  bus error.
- `out_valid`  out  1  result valid to WBU.
- `out_ready`  in  1  WBU accepts result.
- `out_rdata`  out  32  extended load data; 0 for stores.
- `out_err`  out  1  misaligned access, illegal funct3, bus error or timeout.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- `in_ready` = (state==IDLE); it reads 0 while `rst` is asserted.
- IDLE, on `in_valid`:
  - Latch addr, funct3, is_store and wdata.
  - Legality: loads accept funct3 000, 001, 010, 100, 101; stores accept 000, 001, 010.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal or misaligned goes to DONE with err=1; no bus request is ever issued.
  - Otherwise go to REQ.
- REQ: `mem_req_valid`=1 with registered addr/wen/wmask/wdata, all stable until `mem_req_ready`. On handshake go to WAIT and clear the timeout counter.
- WAIT: the counter increments each cycle.
  - `mem_resp_valid` goes to DONE, capturing the extended data and err = `mem_resp_err`.
  - If the counter reaches `TIMEOUT_CYCLES` without a response, go to DONE with err=1 and rdata=0.
  - If both occur in the same cycle, the response wins.
- DONE: `out_valid`=1 and the outputs stay stable until `out_ready`, then return to IDLE. No new request is accepted in the same cycle (single outstanding).
- `mem_resp_valid` outside WAIT is ignored.
- Store formatting: `STORE_Decoder` is instantiated on the latched addr/funct3/wdata.
  - SB: mask `1<<off`, data `<<8*off`.
  - SH: mask `3<<off`.
  - SW: mask `0x0F`.
  - `mem_wmask[7:4]` is always 0.
- Loads: `mem_wen`=0, `mem_wmask`=0, `mem_wdata`=0.
  - Byte select is `rdata>>8*off`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.

## Timing
- Reset values: `mem_req_valid`=0, `mem_addr`=0, `mem_wen`=0, `mem_wmask`=0, `mem_wdata`=0, `out_valid`=0, `out_rdata`=0, `out_err`=0, counter=0.
- Reset mid-transaction: immediate return to IDLE. Any in-flight bus response is dropped, and the bus is required to be reset together with the controller.
- All bus and result outputs are registered; no combinational path from `in_*` to `mem_*`.
- Minimum legal access: accept at cycle 0, `mem_req_valid` at cycle 1; with ready=1 at cycle 1 and a response at cycle 2, `out_valid` is at cycle 3. Throughput is one access per 4 cycles minimum.
- Error path: accept at cycle 0, `out_valid` at cycle 1.
- Timeout: `out_valid` appears `TIMEOUT_CYCLES`+1 cycles after the request handshake.
- Backpressure: holding `mem_req_ready`=0 or `out_ready`=0 stalls indefinitely with outputs held.

## Structure
- The shared package holds:
  - the `FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW` constants (existing defines);
  - the state enum `lsu_state_t`.
- Sub-module `lsu_load_align` (combinational: rdata, off, funct3 → extended data).
- Reuses `STORE_Decoder` unchanged.

## Test plan
- SB, addr 0x8000_0003, wdata 0x0000_00AB → `mem_addr`=0x8000_0000, `mem_wmask`=0x08, `mem_wdata`=0xAB00_0000, `mem_wen`=1; `out_err`=0, `out_rdata`=0.
- LH, addr 0x8000_0002, `mem_rdata`=0x8765_1234 → `out_rdata`=0xFFFF_8765. LHU on the same data → 0x0000_8765.
- SW, addr 0x8000_0001 → `out_valid` 1 cycle after accept with `out_err`=1; `mem_req_valid` never asserted.
- Load with funct3=011 → `out_err`=1, no bus request.
- LW with `mem_req_ready` held 0 for 5 cycles → request fields stable throughout.
- LW with TIMEOUT_CYCLES=4 and no response → `out_err`=1, `out_rdata`=0 at cycle 5 after handshake.
- Response with `mem_resp_err`=1 → `out_err`=1.
- `out_ready` low 3 cycles → `out_valid` and data held, `in_ready`=0.
- `rst` pulsed in WAIT → all outputs 0 and state IDLE. A late response is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared funct3 constants, state type and legality check for lsu_ctrl
package lsu_ctrl_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Legal funct3 for the direction, and naturally aligned for its size.
    function automatic logic lsu_access_ok(input logic is_store, input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            FUNCT3_LB:  ok = 1'b1;
            FUNCT3_LBU: ok = !is_store;
            FUNCT3_LH:  ok = !addr_lo[0];
            FUNCT3_LHU: ok = !is_store && !addr_lo[0];
            FUNCT3_LW:  ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/STORE_Decoder.sv
// rtl/STORE_Decoder.sv - store byte-lane mask and data formatting
module STORE_Decoder
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] src,
    output logic [7:0]  mask,
    output logic [31:0] data
);
    logic [3:0] lane_mask;

    always_comb begin
        lane_mask = 4'h0;
        data      = 32'h0;
        case (funct3)
            FUNCT3_SB: begin
                lane_mask = 4'b0001 << off;
                data      = src << {off, 3'b000};
            end
            FUNCT3_SH: begin
                lane_mask = 4'b0011 << off;
                data      = src << {off, 3'b000};
            end
            FUNCT3_SW: begin
                lane_mask = 4'b1111;
                data      = src;
            end
            default: begin
                lane_mask = 4'h0;
                data      = 32'h0;
            end
        endcase
    end

    assign mask = {4'h0, lane_mask};

endmodule

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load byte selection and sign/zero extension
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        case (funct3)
            FUNCT3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_LBU: data = {24'h0, shifted[7:0]};
            FUNCT3_LHU: data = {16'h0, shifted[15:0]};
            default:    data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller between the EXU and the data-memory bus
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, state_next;
    logic [7:0]  cnt;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
    logic        access_ok;
    logic        timeout_hit;
    logic [7:0]  dec_mask;
    logic [31:0] dec_data;
    logic [31:0] load_data;

    assign access_ok   = lsu_access_ok(in_is_store, in_funct3, in_addr[1:0]);
    assign timeout_hit = (cnt == TIMEOUT_LAST);

    STORE_Decoder u_store_dec (
        .funct3 (lat_funct3),
        .off    (lat_off),
        .src    (lat_wdata),
        .mask   (dec_mask),
        .data   (dec_data)
    );

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .off    (lat_off),
        .funct3 (lat_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = access_ok ? REQ : DONE;
            REQ:     if (mem_req_ready) state_next = WAIT;
            WAIT:    if (mem_resp_valid || timeout_hit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane fields are decoded from latched registers, so nothing from in_* reaches the bus.
    always_comb begin
        in_ready      = (state == IDLE) && !rst;
        mem_req_valid = (state == REQ);
        out_valid     = (state == DONE);
        mem_wmask     = lat_store ? dec_mask : 8'h00;
        mem_wdata     = lat_store ? dec_data : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= 32'h0;
            mem_wen    <= 1'b0;
            lat_store  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            lat_wdata  <= 32'h0;
            cnt        <= 8'h0;
            out_rdata  <= 32'h0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mem_addr   <= {in_addr[31:2], 2'b00};
                    mem_wen    <= in_is_store;
                    lat_store  <= in_is_store;
                    lat_funct3 <= in_funct3;
                    lat_off    <= in_addr[1:0];
                    lat_wdata  <= in_wdata;
                    out_rdata  <= 32'h0;
                    out_err    <= !access_ok;
                end
                REQ: if (mem_req_ready) cnt <= 8'h0;
                WAIT: begin
                    cnt <= cnt + 8'h1;
                    // A response arriving on the timeout cycle still wins.
                    if (mem_resp_valid) begin
                        out_rdata <= lat_store ? 32'h0 : load_data;
                        out_err   <= mem_resp_err;
                    end else if (timeout_hit) begin
                        out_rdata <= 32'h0;
                        out_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with bus and result monitors
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk, rst;
    logic        in_valid, in_ready, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid, mem_resp_err;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    typedef struct { logic err; logic [31:0] rdata; int cyc; } res_t;
    typedef struct { logic [31:0] addr; logic wen; logic [7:0] mask; logic [31:0] wdata; } req_t;

    res_t exp_q[$];
    req_t req_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          cfg_ready_dly = 0;
    int          cfg_resp_dly  = 0;
    int          cfg_stall     = 0;
    logic [31:0] cfg_rdata     = 32'h0;
    logic        cfg_err       = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size = access_size(f3);
        if (size == 0) return 1'b0;
        if (st && f3 > 3'd2) return 1'b0;
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int     off  = int'(a % 4);
        int     size = access_size(f3);
        logic   sgn  = (f3 == 3'd0) || (f3 == 3'd1);
        longint v;
        v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
        if (sgn && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    function automatic req_t model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] wd);
        req_t r;
        int   off = int'(a % 4);
        r.addr  = a & 32'hFFFF_FFFC;
        r.wen   = st;
        r.mask  = 8'h00;
        r.wdata = 32'h0;
        if (st) begin
            if (f3 == 3'd0)      begin r.mask = 8'(1 << off); r.wdata = wd << (8 * off); end
            else if (f3 == 3'd1) begin r.mask = 8'(3 << off); r.wdata = wd << (8 * off); end
            else                 begin r.mask = 8'h0F;        r.wdata = wd;              end
        end
        return r;
    endfunction

    // resp_dly: >=0 cycles into WAIT, -1 never (timeout), -2 only after a reset pulse.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input logic rerr,
                         input int rdly, input int resp_dly, input int stall, input logic wait_done);
        res_t e;
        logic ok;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        cfg_ready_dly = rdly;
        cfg_resp_dly  = resp_dly;
        cfg_stall     = stall;
        cfg_rdata     = rd;
        cfg_err       = rerr;
        ok = model_legal(st, f3, a);
        if (!ok) begin
            e.err = 1'b1; e.rdata = 32'h0; e.cyc = cyc + 1;
        end else if (resp_dly < 0) begin
            e.err = 1'b1; e.rdata = 32'h0; e.cyc = cyc + 2 + rdly + TO;
        end else begin
            e.err = rerr; e.rdata = st ? 32'h0 : model_load(f3, a, rd);
            e.cyc = cyc + 3 + rdly + resp_dly;
        end
        if (ok) req_q.push_back(model_req(st, f3, a, wd));
        if (resp_dly != -2) exp_q.push_back(e);
        in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
        @(negedge clk);
        in_valid = 1'b0; in_is_store = 1'($urandom); in_funct3 = 3'($urandom);
        in_addr = $urandom; in_wdata = $urandom;
        if (wait_done) begin
            n = 0;
            while ((exp_q.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
            if (exp_q.size() != 0 || !in_ready) begin
                chk("complete_timeout", 32'd0, 32'd1);
                exp_q.delete();
                req_q.delete();
            end
        end
    endtask

    // Bus model: checks request fields against the reference, then answers.
    initial begin
        req_t r;
        int   n;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                    mem_req_ready = 1'b1; @(negedge clk); mem_req_ready = 1'b0;
                end else begin
                    r = req_q.pop_front();
                    chk("mem_addr", mem_addr, r.addr);
                    chk("mem_wen", {31'b0, mem_wen}, {31'b0, r.wen});
                    chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, r.mask});
                    chk("mem_wdata", mem_wdata, r.wdata);
                    for (int i = 0; i < cfg_ready_dly; i++) begin
                        @(negedge clk);
                        chk("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
                        chk("req_hold_addr", mem_addr, r.addr);
                        chk("req_hold_wmask", {24'b0, mem_wmask}, {24'b0, r.mask});
                        chk("req_hold_wdata", mem_wdata, r.wdata);
                    end
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    if (cfg_resp_dly >= 0) begin
                        repeat (cfg_resp_dly) @(negedge clk);
                        mem_resp_valid = 1'b1; mem_rdata = cfg_rdata; mem_resp_err = cfg_err;
                        @(negedge clk);
                        mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = $urandom;
                    end else if (cfg_resp_dly == -2) begin
                        n = 0;
                        while (!rst && n < 50) begin @(negedge clk); n++; end
                        while (rst && n < 100) begin @(negedge clk); n++; end
                        mem_resp_valid = 1'b1; mem_rdata = cfg_rdata; mem_resp_err = 1'b1;
                        @(negedge clk);
                        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard whenever a result is presented.
    initial begin
        res_t e;
        int   stall;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                    chk("out_rdata", out_rdata, e.rdata);
                    chk("out_latency", cyc, e.cyc);
                    stall = cfg_stall;
                    for (int i = 0; i < stall; i++) begin
                        @(negedge clk);
                        chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
                        chk("hold_out_rdata", out_rdata, e.rdata);
                        chk("hold_out_err", {31'b0, out_err}, {31'b0, e.err});
                        chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        int          rdly, rsp, st_sel;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b0;
        in_addr = 32'h0; in_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wen_wmask", {23'b0, mem_wen, mem_wmask}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out", {out_valid, out_err, 30'b0} | out_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        issue(1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0, 0, 0, 1);
        issue(0, 3'd1, 32'h8000_0002, 32'h0, 32'h8765_1234, 0, 0, 1, 0, 1);
        issue(0, 3'd5, 32'h8000_0002, 32'h0, 32'h8765_1234, 0, 1, 0, 0, 1);
        issue(1, 3'd2, 32'h8000_0001, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 1);
        issue(0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        issue(0, 3'd2, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0, 5, 0, 0, 1);
        issue(0, 3'd2, 32'h8000_0020, 32'h0, 32'h1111_2222, 0, 0, -1, 0, 1);
        issue(0, 3'd2, 32'h8000_0024, 32'h0, 32'h3333_4444, 1, 0, 2, 0, 1);
        issue(0, 3'd0, 32'h8000_0031, 32'h0, 32'h0000_8000, 0, 0, TO - 1, 0, 1);
        issue(1, 3'd1, 32'h8000_0042, 32'hBEEF_A5C3, 32'h0, 0, 0, 0, 3, 1);

        issue(0, 3'd2, 32'h8000_0050, 32'h0, 32'h5555_AAAA, 0, 0, -2, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_req_out", {mem_req_valid, out_valid, out_err, mem_wen, 28'b0}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_out_rdata", out_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("late_resp_ignored", {30'b0, out_valid, in_ready}, 32'd1);
        end
        issue(0, 3'd2, 32'h8000_0060, 32'h0, 32'h0BAD_CAFE, 0, 0, 1, 0, 1);

        for (int t = 0; t < 150; t++) begin
            st_sel = $urandom_range(0, 1);
            st     = st_sel[0];
            if ($urandom_range(0, 9) < 8) begin
                f3 = st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 3) % 6 == 3 ? 0 : $urandom_range(0, 5));
            end else begin
                f3 = 3'($urandom);
            end
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            rdly = $urandom_range(0, 3);
            rsp  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TO - 1);
            issue(st, f3, a, $urandom, $urandom, ($urandom_range(0, 9) == 0), rdly, rsp,
                  $urandom_range(0, 2), 1);
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", exp_q.size() + req_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
